// File: rtl/ex_mem_pkg.sv
// rtl/ex_mem_pkg.sv - shared widths, MEM control bit indices and payload layout for the EX/MEM stage
package ex_mem_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int REG_ADDR_W_DEF = 5;
  localparam int WB_W_DEF       = 2;
  localparam int MEM_W_DEF      = 2;

  localparam int MEM_WRITE_BIT  = 0;
  localparam int MEM_READ_BIT   = 1;

  // Payload layout at the default widths; the stage rebuilds it at its own parameter widths.
  typedef struct packed {
    logic [WB_W_DEF-1:0]       wb;
    logic [MEM_W_DEF-1:0]      mem;
    logic [DATA_W_DEF-1:0]     alu_out;
    logic [DATA_W_DEF-1:0]     mem_wdata;
    logic [REG_ADDR_W_DEF-1:0] rd_addr;
  } ex_mem_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - generic 2-entry (main + skid) valid/ready pipeline buffer with synchronous flush
module pipe_skid_buf #(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [PAYLOAD_W-1:0] in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [PAYLOAD_W-1:0] out_data_o
);

  logic                 main_valid_q, main_valid_d;
  logic                 skid_valid_q, skid_valid_d;
  logic [PAYLOAD_W-1:0] main_data_q, main_data_d;
  logic [PAYLOAD_W-1:0] skid_data_q, skid_data_d;
  logic                 in_xfer;
  logic                 out_xfer;

  // Ready depends only on registered state, so there is no ready_i -> ready_o path.
  assign in_ready_o  = ~skid_valid_q;
  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_data_q;
  assign in_xfer     = in_valid_i & in_ready_o;
  assign out_xfer    = main_valid_q & out_ready_i;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || out_xfer) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = in_xfer;
        if (in_xfer) skid_data_d = in_data_i;
      end else begin
        main_valid_d = in_xfer;
        if (in_xfer) main_data_d = in_data_i;
      end
    end else if (in_xfer) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/ex_mem_skid_stage.sv
// rtl/ex_mem_skid_stage.sv - EX->MEM pipeline stage with skid buffer, flush and bubble gating; EX_MEM_STALL_CNT_EN adds stall_cnt_o
module ex_mem_skid_stage
  import ex_mem_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int WB_W       = WB_W_DEF,
  parameter int MEM_W      = MEM_W_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [WB_W-1:0]       WB_i,
  input  logic [MEM_W-1:0]      MEM_i,
  input  logic [DATA_W-1:0]     ALUout_i,
  input  logic [DATA_W-1:0]     MemWriteData_i,
  input  logic [REG_ADDR_W-1:0] RegWriteAddr_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_W-1:0]     ALUout_o,
  output logic [DATA_W-1:0]     MemWriteData_o,
  output logic [REG_ADDR_W-1:0] RegWriteAddr_o,
  output logic [WB_W-1:0]       WB_o,
  output logic                  MemWrite_o,
  output logic                  MemRead_o
`ifdef EX_MEM_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt_o
`endif
);

  typedef struct packed {
    logic [WB_W-1:0]       wb;
    logic [MEM_W-1:0]      mem;
    logic [DATA_W-1:0]     alu_out;
    logic [DATA_W-1:0]     mem_wdata;
    logic [REG_ADDR_W-1:0] rd_addr;
  } payload_t;

  localparam int PAYLOAD_W = $bits(payload_t);

  payload_t in_pl;
  payload_t out_pl;

  assign in_pl = '{wb: WB_i, mem: MEM_i, alu_out: ALUout_i,
                   mem_wdata: MemWriteData_i, rd_addr: RegWriteAddr_i};

  pipe_skid_buf #(.PAYLOAD_W(PAYLOAD_W)) u_skid (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .in_valid_i  (valid_i),
    .in_ready_o  (ready_o),
    .in_data_i   (in_pl),
    .out_valid_o (valid_o),
    .out_ready_i (ready_i),
    .out_data_o  (out_pl)
  );

  // Data fields keep their last value on bubbles; control is gated so a bubble never writes.
  assign ALUout_o       = out_pl.alu_out;
  assign MemWriteData_o = out_pl.mem_wdata;
  assign RegWriteAddr_o = out_pl.rd_addr;
  assign WB_o           = valid_o ? out_pl.wb : '0;
  assign MemWrite_o     = valid_o & out_pl.mem[MEM_WRITE_BIT];
  assign MemRead_o      = valid_o & out_pl.mem[MEM_READ_BIT];

`ifdef EX_MEM_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (valid_o && !ready_i && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stall_cnt_q <= 16'd0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
